// File: rtl/sdram_burst_arbiter.sv
// Two-master SDRAM arbiter: urgent-aware, round-robin reader/writer with writer starvation guard.
// Optional grant statistics are compiled in with `define SDRAM_ARB_STATS_EN.
module sdram_burst_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int BURST_W    = 4,
  parameter int STARVE_MAX = 64
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [ADDR_W-1:0]   wr_address,
  input  logic [BURST_W-1:0]  wr_burstcount,
  input  logic [DATA_W-1:0]   wr_writedata,
  input  logic                wr_write,
  output logic                wr_waitrequest,
  input  logic [ADDR_W-1:0]   rd_address,
  input  logic [BURST_W-1:0]  rd_burstcount,
  input  logic                rd_read,
  input  logic                rd_urgent,
  output logic                rd_waitrequest,
  output logic [DATA_W-1:0]   rd_readdata,
  output logic                rd_readdatavalid,
  output logic [ADDR_W-1:0]   sdram_address,
  output logic [BURST_W-1:0]  sdram_burstcount,
  output logic [DATA_W-1:0]   sdram_writedata,
  output logic                sdram_read,
  output logic                sdram_write,
  input  logic                sdram_waitrequest,
  input  logic                sdram_readdatavalid,
  input  logic [DATA_W-1:0]   sdram_readdata,
  output logic [15:0]         stat_wr_grants,
  output logic [15:0]         stat_rd_grants,
  output logic [15:0]         stat_starve_forces
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM  = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_PRE  = STARVE_W'(STARVE_MAX - 1);

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_BURST} state_t;

  state_t                state;
  logic                  last_grant_wr;
  logic [BURST_W-1:0]    beat_cnt;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  force_wr;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [BURST_W-1:0]    wr_bc_q;

  logic rd_win, grant_rd, grant_wr, beat_acc, starve_inc;

  function automatic logic [BURST_W-1:0] norm_burst(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A pending forced write only blocks the reader while the writer is still asking.
  always_comb begin
    rd_win     = rd_read && (rd_urgent || last_grant_wr || !wr_write) && !(force_wr && wr_write);
    grant_rd   = (state == IDLE) && rd_win;
    grant_wr   = (state == IDLE) && !rd_win && wr_write;
    beat_acc   = (state == WR_BURST) && !sdram_waitrequest;
    starve_inc = wr_write && (state != WR_BURST) && !grant_wr;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state         <= IDLE;
      last_grant_wr <= 1'b1;
      beat_cnt      <= '0;
      starve_cnt    <= '0;
      force_wr      <= 1'b0;
      sdram_read    <= 1'b0;
      sdram_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_rd) begin
            state      <= RD_CMD;
            sdram_read <= 1'b1;
          end else if (grant_wr) begin
            state       <= WR_BURST;
            sdram_write <= 1'b1;
            beat_cnt    <= norm_burst(wr_burstcount);
          end
        end
        RD_CMD: begin
          if (!sdram_waitrequest) begin
            state         <= IDLE;
            sdram_read    <= 1'b0;
            last_grant_wr <= 1'b0;
          end
        end
        WR_BURST: begin
          if (beat_acc) begin
            beat_cnt <= beat_cnt - BURST_W'(1);
            if (beat_cnt == BURST_W'(1)) begin
              state         <= IDLE;
              sdram_write   <= 1'b0;
              last_grant_wr <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (grant_wr) begin
        starve_cnt <= '0;
        force_wr   <= 1'b0;
      end else if (starve_inc && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
        if (starve_cnt == STARVE_PRE) force_wr <= 1'b1;
      end
    end
  end

  // Write command is frozen at grant so the writer may move on to its next address.
  always_ff @(posedge clk_clk) begin
    if (grant_wr) begin
      wr_addr_q <= wr_address;
      wr_bc_q   <= norm_burst(wr_burstcount);
    end
  end

  always_comb begin
    sdram_address    = (state == RD_CMD) ? rd_address : wr_addr_q;
    sdram_burstcount = (state == RD_CMD) ? norm_burst(rd_burstcount) : wr_bc_q;
    sdram_writedata  = wr_writedata;
    rd_waitrequest   = (state == RD_CMD)   ? sdram_waitrequest : 1'b1;
    wr_waitrequest   = (state == WR_BURST) ? sdram_waitrequest : 1'b1;
    rd_readdata      = sdram_readdata;
    rd_readdatavalid = sdram_readdatavalid;
  end

`ifdef SDRAM_ARB_STATS_EN
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stat_wr_grants     <= '0;
      stat_rd_grants     <= '0;
      stat_starve_forces <= '0;
    end else begin
      if (grant_wr)             stat_wr_grants     <= sat_inc(stat_wr_grants);
      if (grant_rd)             stat_rd_grants     <= sat_inc(stat_rd_grants);
      if (grant_wr && force_wr) stat_starve_forces <= sat_inc(stat_starve_forces);
    end
  end
`else
  assign stat_wr_grants     = '0;
  assign stat_rd_grants     = '0;
  assign stat_starve_forces = '0;
`endif

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Scoreboard bench for sdram_burst_arbiter: expected SDRAM commands are queued by each test
// and popped by a monitor whenever the SDRAM bus accepts a command beat.
module tb_sdram_burst_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int BURST_W = 4;
`ifdef SDRAM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk_clk = 1'b0;
  logic reset_reset;
  logic [ADDR_W-1:0]  wr_address, rd_address, sdram_address;
  logic [BURST_W-1:0] wr_burstcount, rd_burstcount, sdram_burstcount;
  logic [DATA_W-1:0]  wr_writedata, rd_readdata, sdram_writedata, sdram_readdata;
  logic wr_write, wr_waitrequest, rd_read, rd_urgent, rd_waitrequest, rd_readdatavalid;
  logic sdram_read, sdram_write, sdram_waitrequest, sdram_readdatavalid;
  logic [15:0] stat_wr_grants, stat_rd_grants, stat_starve_forces;

  logic stall_toggle;
  logic [31:0] cyc = '0;
  assign sdram_waitrequest = stall_toggle & cyc[0];
  always @(posedge clk_clk) cyc <= cyc + 32'd1;
  always #5 clk_clk = ~clk_clk;

  sdram_burst_arbiter dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .wr_address(wr_address), .wr_burstcount(wr_burstcount), .wr_writedata(wr_writedata),
    .wr_write(wr_write), .wr_waitrequest(wr_waitrequest),
    .rd_address(rd_address), .rd_burstcount(rd_burstcount), .rd_read(rd_read),
    .rd_urgent(rd_urgent), .rd_waitrequest(rd_waitrequest),
    .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid),
    .sdram_address(sdram_address), .sdram_burstcount(sdram_burstcount),
    .sdram_writedata(sdram_writedata), .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_waitrequest(sdram_waitrequest), .sdram_readdatavalid(sdram_readdatavalid),
    .sdram_readdata(sdram_readdata),
    .stat_wr_grants(stat_wr_grants), .stat_rd_grants(stat_rd_grants),
    .stat_starve_forces(stat_starve_forces)
  );

  typedef struct packed {
    logic               is_wr;
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] bc;
    logic [DATA_W-1:0]  data;
  } txn_t;

  txn_t exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;
  int wr_hi_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input int n, input logic [DATA_W-1:0] d0);
    txn_t t;
    for (int k = 0; k < n; k++) begin
      t.is_wr = 1'b1; t.addr = a; t.bc = BURST_W'(n); t.data = d0 + DATA_W'(k);
      exp_q.push_back(t);
    end
  endtask

  task automatic push_rd(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc);
    txn_t t;
    t.is_wr = 1'b0; t.addr = a; t.bc = bc; t.data = '0;
    exp_q.push_back(t);
  endtask

  task automatic do_writes(input logic [ADDR_W-1:0] a0, input int nb,
                           input logic [BURST_W-1:0] bc, input logic [DATA_W-1:0] d0);
    int n;
    bit acc;
    int g;
    n = (bc == '0) ? 1 : int'(bc);
    for (int b = 0; b < nb; b++) begin
      wr_write = 1'b1; wr_address = a0 + ADDR_W'(b * 'h40); wr_burstcount = bc;
      for (int k = 0; k < n; k++) begin
        wr_writedata = d0 + DATA_W'(b * 16 + k);
        acc = 1'b0; g = 0;
        while (!acc && g < 400) begin
          @(negedge clk_clk); acc = !wr_waitrequest;
          @(posedge clk_clk); #1; g++;
        end
        if (!acc) begin
          vec_cnt++; err_cnt++;
          $display("FAIL wr_timeout: beat %0d got no acceptance, expected one within 400 cycles", k);
        end
      end
    end
    wr_write = 1'b0;
  endtask

  task automatic do_reads(input logic [ADDR_W-1:0] a0, input int nr,
                          input logic [BURST_W-1:0] bc, input logic urg);
    bit acc;
    int g;
    for (int i = 0; i < nr; i++) begin
      rd_read = 1'b1; rd_address = a0 + ADDR_W'(i); rd_burstcount = bc; rd_urgent = urg;
      acc = 1'b0; g = 0;
      while (!acc && g < 400) begin
        @(negedge clk_clk); acc = !rd_waitrequest;
        @(posedge clk_clk); #1; g++;
      end
      if (!acc) begin
        vec_cnt++; err_cnt++;
        $display("FAIL rd_timeout: read %0d got no acceptance, expected one within 400 cycles", i);
      end
    end
    rd_read = 1'b0; rd_urgent = 1'b0;
  endtask

  task automatic apply_reset();
    reset_reset = 1'b1;
    repeat (2) @(posedge clk_clk);
    #1 reset_reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi0;
    reset_reset = 1'b1; stall_toggle = 1'b0;
    wr_address = '0; wr_burstcount = '0; wr_writedata = '0; wr_write = 1'b0;
    rd_address = '0; rd_burstcount = '0; rd_read = 1'b0; rd_urgent = 1'b0;
    sdram_readdatavalid = 1'b0; sdram_readdata = '0;

    fork
      begin : monitor
        txn_t e, a;
        forever begin
          @(negedge clk_clk);
          if (sdram_write) wr_hi_total++;
          if (!reset_reset && (sdram_read || sdram_write) && !sdram_waitrequest) begin
            a.is_wr = sdram_write; a.addr = sdram_address; a.bc = sdram_burstcount;
            a.data = sdram_write ? sdram_writedata : '0;
            vec_cnt++;
            if (exp_q.size() == 0) begin
              err_cnt++;
              $display("FAIL unexpected_cmd: got wr=%0b addr=%0h bc=%0d data=%0h, expected no command",
                       a.is_wr, a.addr, a.bc, a.data);
            end else begin
              e = exp_q.pop_front();
              if (a !== e) begin
                err_cnt++;
                $display("FAIL cmd: got wr=%0b addr=%0h bc=%0d data=%0h, expected wr=%0b addr=%0h bc=%0d data=%0h",
                         a.is_wr, a.addr, a.bc, a.data, e.is_wr, e.addr, e.bc, e.data);
              end
            end
          end
        end
      end
    join_none

    // Reset held two cycles
    repeat (2) @(posedge clk_clk);
    #1;
    check("rst_sdram_read", sdram_read, 0);
    check("rst_sdram_write", sdram_write, 0);
    check("rst_wr_wait", wr_waitrequest, 1);
    check("rst_rd_wait", rd_waitrequest, 1);
    check("rst_stat_wr", stat_wr_grants, 0);
    check("rst_stat_rd", stat_rd_grants, 0);
    check("rst_stat_force", stat_starve_forces, 0);
    reset_reset = 1'b0;
    @(posedge clk_clk); #1;

    // Single 4-beat write, one-cycle grant latency
    push_wr(24'h000100, 4, 16'hA000);
    hi0 = wr_hi_total;
    fork
      do_writes(24'h000100, 1, 4'd4, 16'hA000);
      begin
        @(negedge clk_clk); check("wr_lat_cycle1", sdram_write, 0);
        @(negedge clk_clk); check("wr_lat_cycle2", sdram_write, 1);
      end
    join
    @(negedge clk_clk);
    check("wr4_back_idle", sdram_write, 0);
    check("wr4_high_cycles", wr_hi_total - hi0, 4);
    check("wr4_stat_wr", stat_wr_grants, STATS ? 1 : 0);
    check("wr4_q_empty", exp_q.size(), 0);

    // Simultaneous requests alternate, reader first after reset
    @(posedge clk_clk); #1;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      push_rd(24'h000200 + ADDR_W'(i), 4'd4);
      push_wr(24'h000300 + ADDR_W'(i * 'h40), 2, 16'hB000 + DATA_W'(i * 16));
    end
    fork
      do_reads(24'h000200, 3, 4'd4, 1'b0);
      do_writes(24'h000300, 3, 4'd2, 16'hB000);
    join
    check("alt_q_empty", exp_q.size(), 0);
    check("alt_stat_rd", stat_rd_grants, STATS ? 3 : 0);

    // Burstcount zero is one beat
    push_wr(24'h000400, 1, 16'hC000);
    do_writes(24'h000400, 1, 4'd0, 16'hC000);
    @(negedge clk_clk);
    check("bc0_q_empty", exp_q.size(), 0);
    check("bc0_idle", sdram_write, 0);

    // 8-beat write with waitrequest toggling
    apply_reset();
    stall_toggle = 1'b1;
    push_wr(24'h000500, 8, 16'hD000);
    do_writes(24'h000500, 1, 4'd8, 16'hD000);
    stall_toggle = 1'b0;
    @(negedge clk_clk);
    check("stall8_q_empty", exp_q.size(), 0);
    check("stall8_idle", sdram_write, 0);

    // Urgent reader: writer forced in after 64 held-off cycles (32 reads)
    apply_reset();
    for (int i = 0; i < 32; i++) push_rd(24'h001000 + ADDR_W'(i), 4'd4);
    push_wr(24'h002000, 1, 16'hE000);
    for (int i = 32; i < 40; i++) push_rd(24'h001000 + ADDR_W'(i), 4'd4);
    fork
      do_reads(24'h001000, 40, 4'd4, 1'b1);
      do_writes(24'h002000, 1, 4'd1, 16'hE000);
    join
    check("starve_q_empty", exp_q.size(), 0);
    check("starve_stat_rd", stat_rd_grants, STATS ? 40 : 0);
    check("starve_stat_wr", stat_wr_grants, STATS ? 1 : 0);
    check("starve_stat_force", stat_starve_forces, STATS ? 1 : 0);

    // Reset during third beat of an 8-beat write; read data still forwarded
    apply_reset();
    push_wr(24'h000600, 8, 16'hF000);
    exp_q.pop_back(); exp_q.pop_back(); exp_q.pop_back();
    exp_q.pop_back(); exp_q.pop_back(); exp_q.pop_back();
    @(posedge clk_clk); #1;
    wr_write = 1'b1; wr_address = 24'h000600; wr_burstcount = 4'd8; wr_writedata = 16'hF000;
    @(posedge clk_clk); #1;
    @(posedge clk_clk); #1; wr_writedata = 16'hF001;
    @(posedge clk_clk); #1; wr_writedata = 16'hF002; reset_reset = 1'b1;
    sdram_readdatavalid = 1'b1; sdram_readdata = 16'h5A5A;
    #1;
    check("rst_pass_valid", rd_readdatavalid, 1);
    check("rst_pass_data", rd_readdata, 16'h5A5A);
    @(posedge clk_clk); #1;
    check("abort_sdram_write", sdram_write, 0);
    check("abort_wr_wait", wr_waitrequest, 1);
    check("abort_rd_wait", rd_waitrequest, 1);
    check("abort_pass_data", rd_readdata, 16'h5A5A);
    wr_write = 1'b0; sdram_readdatavalid = 1'b0; reset_reset = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    check("abort_still_idle", sdram_write, 0);
    check("abort_pass_valid0", rd_readdatavalid, 0);
    check("abort_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
